// File: rtl/pic_host_pkg.sv
// Shared types and constants for the 8259A host-side interrupt-acknowledge logic.
package pic_host_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        StHold,
        StIdle,
        StLow,
        StGap,
        StDone
    } state_e;

    // 8080/85 CALL opcode the PIC returns on the first INTA_n pulse
    localparam logic [7:0] CALL_OPCODE = 8'hCD;
    // Flops in the INT input synchroniser
    localparam int unsigned SYNC_DEPTH = 2;
    // Cycles spent in HOLD so a stale synchronised INT is flushed
    localparam int unsigned HOLDOFF_CYC = 2;

endpackage

// File: rtl/inta_sequencer_if.sv
// PIC-facing and CPU-facing signals of the INTA sequencer.
// master: the sequencer; slave: the PIC/CPU side driving it.
interface inta_sequencer_if;
    logic       int_i;
    logic       ack_en_i;
    logic [7:0] d_i;
    logic       INTA_n;
    logic       busy_o;
    logic       vec_valid_o;
    logic [15:0] vec_o;
    logic       vec_ready_i;
    logic       opcode_err_o;

    modport master (
        input  int_i, ack_en_i, d_i, vec_ready_i,
        output INTA_n, busy_o, vec_valid_o, vec_o, opcode_err_o
    );

    modport slave (
        output int_i, ack_en_i, d_i, vec_ready_i,
        input  INTA_n, busy_o, vec_valid_o, vec_o, opcode_err_o
    );
endinterface

// File: rtl/int_sync.sv
// Multi-flop synchroniser for an asynchronous level input, reset to 0.
module int_sync
    import pic_host_pkg::*;
#(
    parameter int unsigned Stages = SYNC_DEPTH
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [Stages-1:0] sync_q;

    // Shift the raw input through the flop chain
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[Stages-2:0], d_i};
        end
    end

    assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/inta_sequencer.sv
// Host-side 8259A interrupt-acknowledge initiator: drives the INTA_n pulse
// train, captures the vector bytes and presents them over valid/ready.
// Optional: define INTA_COUNT_EN to add a saturating handshake counter
// (ack_cnt_o) with a synchronous clear (ack_cnt_clr_i).
module inta_sequencer
    import pic_host_pkg::*;
#(
    parameter bit          MODE_8086     = 1'b1,
    parameter int unsigned PULSE_LOW_CYC = 2,
    parameter int unsigned GAP_CYC       = 2
) (
    input  logic clk,
    input  logic rst_n,
`ifdef INTA_COUNT_EN
    input  logic        ack_cnt_clr_i,
    output logic [15:0] ack_cnt_o,
`endif
    inta_sequencer_if.master bus
);

    localparam logic [3:0] PulseCnt  = 4'(PULSE_LOW_CYC);
    localparam logic [3:0] GapCnt    = 4'(GAP_CYC);
    localparam logic [3:0] HoldCnt   = 4'(HOLDOFF_CYC);
    localparam logic [1:0] LastPulse = MODE_8086 ? 2'd1 : 2'd2;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  pidx_q, pidx_d;
    logic [15:0] vec_q, vec_d;
    logic        err_q, err_d;
    logic        int_s;
    logic        handshake;

    int_sync #(
        .Stages (SYNC_DEPTH)
    ) u_int_sync (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .d_i    (bus.int_i),
        .q_o    (int_s)
    );

    assign handshake = (state_q == StDone) && bus.vec_ready_i;

    // State, phase counter, pulse index and captured result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StHold;
            cnt_q   <= HoldCnt;
            pidx_q  <= 2'd0;
            vec_q   <= 16'h0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pidx_q  <= pidx_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
        end
    end

    // Next-state: phase timing and byte capture at the end of each low phase
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pidx_d  = pidx_q;
        vec_d   = vec_q;
        err_d   = err_q;
        unique case (state_q)
            StHold: begin
                if (cnt_q <= 4'd1) state_d = StIdle;
                else               cnt_d   = cnt_q - 4'd1;
            end
            StIdle: begin
                if (int_s && bus.ack_en_i) begin
                    state_d = StLow;
                    cnt_d   = PulseCnt;
                    pidx_d  = 2'd0;
                    err_d   = 1'b0;
                end
            end
            StLow: begin
                if (cnt_q == 4'd1) begin
                    if (MODE_8086) begin
                        // Pulse 0 only freezes the PIC; its data is meaningless
                        if (pidx_q == 2'd1) vec_d = {8'h00, bus.d_i};
                    end else begin
                        case (pidx_q)
                            2'd0:    err_d        = (bus.d_i != CALL_OPCODE);
                            2'd1:    vec_d[7:0]   = bus.d_i;
                            default: vec_d[15:8]  = bus.d_i;
                        endcase
                    end
                    if (pidx_q == LastPulse) begin
                        state_d = StDone;
                    end else begin
                        state_d = StGap;
                        cnt_d   = GapCnt;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StGap: begin
                if (cnt_q == 4'd1) begin
                    state_d = StLow;
                    cnt_d   = PulseCnt;
                    pidx_d  = pidx_q + 2'd1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: begin
                if (handshake) begin
                    state_d = StHold;
                    cnt_d   = HoldCnt;
                end
            end
            default: begin
                state_d = StHold;
                cnt_d   = HoldCnt;
            end
        endcase
    end

    // Outputs decoded from registered state so reset forces INTA_n high at once
    always_comb begin
        bus.INTA_n       = (state_q != StLow);
        bus.busy_o       = (state_q == StLow) || (state_q == StGap) || (state_q == StDone);
        bus.vec_valid_o  = (state_q == StDone);
        bus.vec_o        = vec_q;
        bus.opcode_err_o = MODE_8086 ? 1'b0 : err_q;
    end

`ifdef INTA_COUNT_EN
    logic [15:0] ack_cnt_q;

    // Saturating count of completed handshakes; clear beats increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_cnt_q <= 16'h0000;
        end else if (ack_cnt_clr_i) begin
            ack_cnt_q <= 16'h0000;
        end else if (handshake && (ack_cnt_q != 16'hFFFF)) begin
            ack_cnt_q <= ack_cnt_q + 16'd1;
        end
    end

    assign ack_cnt_o = ack_cnt_q;
`endif

endmodule

// File: tb/tb_inta_sequencer.sv
// Directed bench: one 8086-mode (2/2) and one 8080-mode (1/3) sequencer.
module tb_inta_sequencer;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    inta_sequencer_if if86 ();
    inta_sequencer_if if80 ();

`ifdef INTA_COUNT_EN
    logic        clr86, clr80;
    logic [15:0] cnt86, cnt80;
`endif

    inta_sequencer #(
        .MODE_8086     (1'b1),
        .PULSE_LOW_CYC (2),
        .GAP_CYC       (2)
    ) u_dut86 (
        .clk           (clk),
        .rst_n         (rst_n),
`ifdef INTA_COUNT_EN
        .ack_cnt_clr_i (clr86),
        .ack_cnt_o     (cnt86),
`endif
        .bus           (if86)
    );

    inta_sequencer #(
        .MODE_8086     (1'b0),
        .PULSE_LOW_CYC (1),
        .GAP_CYC       (3)
    ) u_dut80 (
        .clk           (clk),
        .rst_n         (rst_n),
`ifdef INTA_COUNT_EN
        .ack_cnt_clr_i (clr80),
        .ack_cnt_o     (cnt80),
`endif
        .bus           (if80)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        if86.int_i = 1'b0; if86.ack_en_i = 1'b0; if86.d_i = 8'h00; if86.vec_ready_i = 1'b0;
        if80.int_i = 1'b0; if80.ack_en_i = 1'b0; if80.d_i = 8'h00; if80.vec_ready_i = 1'b0;
`ifdef INTA_COUNT_EN
        clr86 = 1'b0;
        clr80 = 1'b0;
`endif
        #1;
        chk("rst_inta",  {15'd0, if86.INTA_n}, 16'h0001);
        chk("rst_busy",  {15'd0, if86.busy_o}, 16'h0000);
        chk("rst_valid", {15'd0, if86.vec_valid_o}, 16'h0000);
        chk("rst_vec",   if86.vec_o, 16'h0000);
        chk("rst_err80", {15'd0, if80.opcode_err_o}, 16'h0000);
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();

        // 8086: FF on pulse 0, 4B on pulse 1
        if86.int_i = 1'b1; if86.ack_en_i = 1'b1; if86.d_i = 8'hFF;
        tick(); tick();
        chk("86_no_fall_e2", {15'd0, if86.INTA_n}, 16'h0001);
        tick();
        chk("86_fall_e3", {15'd0, if86.INTA_n}, 16'h0000);
        chk("86_busy_e3", {15'd0, if86.busy_o}, 16'h0001);
        tick();
        chk("86_low_e4", {15'd0, if86.INTA_n}, 16'h0000);
        tick();
        chk("86_gap_e5", {15'd0, if86.INTA_n}, 16'h0001);
        if86.d_i = 8'h4B;
        tick();
        chk("86_gap_e6", {15'd0, if86.INTA_n}, 16'h0001);
        tick();
        chk("86_low2_e7", {15'd0, if86.INTA_n}, 16'h0000);
        tick();
        chk("86_low2_e8", {15'd0, if86.INTA_n}, 16'h0000);
        tick();
        chk("86_valid", {15'd0, if86.vec_valid_o}, 16'h0001);
        chk("86_vec", if86.vec_o, 16'h004B);
        chk("86_err0", {15'd0, if86.opcode_err_o}, 16'h0000);
        chk("86_inta_done", {15'd0, if86.INTA_n}, 16'h0001);

        // Backpressure: result held, no new pulses, bus changes ignored
        if86.d_i = 8'hAA;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_valid", {15'd0, if86.vec_valid_o}, 16'h0001);
            chk("bp_vec", if86.vec_o, 16'h004B);
            chk("bp_inta", {15'd0, if86.INTA_n}, 16'h0001);
        end

        // Handshake, then back-to-back with INT still high
        if86.vec_ready_i = 1'b1;
        tick();
        if86.vec_ready_i = 1'b0;
        chk("hs_valid_drop", {15'd0, if86.vec_valid_o}, 16'h0000);
        chk("hs_busy_drop", {15'd0, if86.busy_o}, 16'h0000);
        tick();
        chk("b2b_hold2", {15'd0, if86.INTA_n}, 16'h0001);
        tick();
        chk("b2b_idle", {15'd0, if86.INTA_n}, 16'h0001);
        tick();
        chk("b2b_fall", {15'd0, if86.INTA_n}, 16'h0000);

        // INT and enable vanish mid-sequence; PIC returns IR7 vector
        if86.int_i = 1'b0; if86.ack_en_i = 1'b0; if86.d_i = 8'h3F;
        tick(); tick(); tick(); tick();
        chk("spur_low2", {15'd0, if86.INTA_n}, 16'h0000);
        tick(); tick();
        chk("spur_valid", {15'd0, if86.vec_valid_o}, 16'h0001);
        chk("spur_vec", if86.vec_o, 16'h003F);
        if86.vec_ready_i = 1'b1;
        tick();
        if86.vec_ready_i = 1'b0;
        chk("spur_hs", {15'd0, if86.vec_valid_o}, 16'h0000);

        // Gating by ack_en_i
        if86.int_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("gate_inta", {15'd0, if86.INTA_n}, 16'h0001);
        end
        if86.ack_en_i = 1'b1;
        tick();
        chk("gate_start", {15'd0, if86.INTA_n}, 16'h0000);
        tick(); tick(); tick(); tick();
        chk("rst_pre_low2", {15'd0, if86.INTA_n}, 16'h0000);

        // Asynchronous reset in the middle of pulse 1
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_inta", {15'd0, if86.INTA_n}, 16'h0001);
        chk("mid_rst_valid", {15'd0, if86.vec_valid_o}, 16'h0000);
        chk("mid_rst_busy", {15'd0, if86.busy_o}, 16'h0000);
        if86.int_i = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("post_rst_quiet", {15'd0, if86.INTA_n | ~if86.vec_valid_o}, 16'h0001);
        end
        if86.int_i = 1'b1;
        tick(); tick();
        chk("fresh_no_fall", {15'd0, if86.INTA_n}, 16'h0001);
        tick();
        chk("fresh_fall", {15'd0, if86.INTA_n}, 16'h0000);
        // Early ready must be ignored until DONE
        if86.int_i = 1'b0; if86.vec_ready_i = 1'b1; if86.d_i = 8'h77;
        tick(); tick(); tick(); tick(); tick();
        chk("fresh_low2", {15'd0, if86.INTA_n}, 16'h0000);
        tick();
        chk("fresh_valid", {15'd0, if86.vec_valid_o}, 16'h0001);
        chk("fresh_vec", if86.vec_o, 16'h0077);
        tick();
        chk("fresh_hs", {15'd0, if86.vec_valid_o}, 16'h0000);
        if86.vec_ready_i = 1'b0;

        // 8080 mode, 1-cycle pulses, 3-cycle gaps: CD 20 30
        if80.int_i = 1'b1; if80.ack_en_i = 1'b1; if80.d_i = 8'hCD;
        tick(); tick(); tick();
        chk("80_fall", {15'd0, if80.INTA_n}, 16'h0000);
        tick();
        chk("80_gap1", {15'd0, if80.INTA_n}, 16'h0001);
        if80.d_i = 8'h20;
        tick(); tick();
        chk("80_gap1_end", {15'd0, if80.INTA_n}, 16'h0001);
        tick();
        chk("80_low2", {15'd0, if80.INTA_n}, 16'h0000);
        tick();
        chk("80_gap2", {15'd0, if80.INTA_n}, 16'h0001);
        if80.d_i = 8'h30;
        tick(); tick(); tick();
        chk("80_low3", {15'd0, if80.INTA_n}, 16'h0000);
        tick();
        chk("80_valid", {15'd0, if80.vec_valid_o}, 16'h0001);
        chk("80_vec", if80.vec_o, 16'h3020);
        chk("80_err0", {15'd0, if80.opcode_err_o}, 16'h0000);
        if80.int_i = 1'b0; if80.vec_ready_i = 1'b1;
        tick();
        if80.vec_ready_i = 1'b0;
        chk("80_hs", {15'd0, if80.vec_valid_o}, 16'h0000);
        tick(); tick(); tick();

        // Bad opcode C3, then 55 66
        if80.int_i = 1'b1; if80.d_i = 8'hC3;
        tick(); tick(); tick();
        chk("80b_fall", {15'd0, if80.INTA_n}, 16'h0000);
        tick();
        chk("80b_err", {15'd0, if80.opcode_err_o}, 16'h0001);
        if80.d_i = 8'h55;
        tick(); tick(); tick(); tick();
        if80.d_i = 8'h66;
        tick(); tick(); tick(); tick();
        chk("80b_valid", {15'd0, if80.vec_valid_o}, 16'h0001);
        chk("80b_vec", if80.vec_o, 16'h6655);
        chk("80b_err_hold", {15'd0, if80.opcode_err_o}, 16'h0001);
        if80.vec_ready_i = 1'b1;
        tick();
        if80.vec_ready_i = 1'b0;
        if80.d_i = 8'hCD;
        // INT still high: HOLD, HOLD, IDLE, then the next start clears the flag
        tick(); tick();
        chk("80c_err_kept", {15'd0, if80.opcode_err_o}, 16'h0001);
        tick();
        chk("80c_fall", {15'd0, if80.INTA_n}, 16'h0000);
        chk("80c_err_clr", {15'd0, if80.opcode_err_o}, 16'h0000);

`ifdef INTA_COUNT_EN
        chk("cnt86", cnt86, 16'd1);
        chk("cnt80", cnt80, 16'd2);
        clr86 = 1'b1; clr80 = 1'b1;
        tick();
        clr86 = 1'b0; clr80 = 1'b0;
        chk("cnt86_clr", cnt86, 16'd0);
        chk("cnt80_clr", cnt80, 16'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
